// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: run controller for the RVCPU simulation harness.
// Holds the core in reset for a fixed number of cycles after rst release,
// then counts run cycles and retired instructions. The run ends on a store
// to TOHOST_ADDR (PASS when the data is 1, otherwise FAIL), on a cycle
// budget (TIMEOUT) or on a retire stall (HANG). Terminal states are
// absorbing until rst is asserted again.
// Ports:
//   clk           clock, all state on rising edge
//   rst           asynchronous active-low reset
//   retire        core retired one instruction this cycle
//   st_valid      core data store valid this cycle
//   st_addr       store address
//   st_data       store data
//   cpu_rst       active-high reset to the core (registered)
//   done          run finished (sticky)
//   pass          run finished with tohost==1 (sticky)
//   status        0 HOLD, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT, 5 HANG
//   fail_code     st_data>>1 of the failing tohost write, else 0
//   cycle_count   cycles spent in RUN (saturating)
//   instret_count retire pulses counted in RUN (saturating)
module sim_run_ctrl #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     CNT_W       = 32,
  parameter int unsigned     RST_CYCLES  = 2,
  parameter int unsigned     MAX_CYCLES  = 100,
  parameter int unsigned     STALL_LIMIT = 64,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 'h1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             retire,
  input  logic             st_valid,
  input  logic [XLEN-1:0]  st_addr,
  input  logic [XLEN-1:0]  st_data,
  output logic             cpu_rst,
  output logic             done,
  output logic             pass,
  output logic [2:0]       status,
  output logic [XLEN-2:0]  fail_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4,
    S_HANG    = 3'd5
  } state_t;

  // A zero reset length still holds the core for one edge.
  localparam int unsigned      RST_EFF   = (RST_CYCLES == 0) ? 1 : RST_CYCLES;
  localparam int unsigned      HOLD_W    = $clog2(RST_EFF + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_EFF - 1);
  localparam logic [CNT_W-1:0]  MAX_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STALL_LAST = CNT_W'(STALL_LIMIT - 1);

  state_t             state, state_next;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [CNT_W-1:0]   stall_cnt;
  logic               tohost_hit;
  logic               timeout_hit;
  logic               hang_hit;

  assign status = state;

  always_comb begin
    state_next  = state;
    tohost_hit  = st_valid && (st_addr == TOHOST_ADDR);
    timeout_hit = (MAX_CYCLES != 0) && (cycle_count == MAX_LAST);
    hang_hit    = (STALL_LIMIT != 0) && (stall_cnt == STALL_LAST) && !retire;
    case (state)
      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) state_next = S_RUN;
      end
      S_RUN: begin
        if (tohost_hit)       state_next = (st_data == XLEN'(1)) ? S_PASS : S_FAIL;
        else if (timeout_hit) state_next = S_TIMEOUT;
        else if (hang_hit)    state_next = S_HANG;
      end
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_HOLD;
      hold_cnt      <= '0;
      cpu_rst       <= 1'b1;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail_code     <= '0;
      cycle_count   <= '0;
      instret_count <= '0;
      stall_cnt     <= '0;
    end else begin
      state   <= state_next;
      // Outputs follow the next state so they change on the same edge as state.
      cpu_rst <= (state_next == S_HOLD);
      done    <= (state_next != S_HOLD) && (state_next != S_RUN);
      pass    <= (state_next == S_PASS);

      if (state == S_HOLD) hold_cnt <= hold_cnt + 1'b1;

      if (state == S_RUN) begin
        if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
        if (retire && (instret_count != '1)) instret_count <= instret_count + 1'b1;
        if (retire)                stall_cnt <= '0;
        else if (stall_cnt != '1)  stall_cnt <= stall_cnt + 1'b1;
        if (state_next == S_FAIL)  fail_code <= st_data[XLEN-1:1];
      end
    end
  end

endmodule
